// File: rtl/mipi_cmd_seq.sv
// MIPI DSI command-packet sequencer: round-robin grant of NUM_CH requests
// to one DSI TX command port, with ack retry, TX timeout and packet gap.
module mipi_cmd_seq #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter int ACK_TIMEOUT = 1000,
  parameter int MAX_RETRY   = 2,
  parameter int TX_TIMEOUT  = 60000,
  parameter int GAP_CYCLES  = 333,
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clkin,
  input  logic              rstn,
  input  logic [NUM_CH-1:0] start,
  input  logic [NUM_CH-1:0] hs_cfg,
  output logic              cmd_rq,
  output logic [CHW-1:0]    cmd_ch,
  output logic              hs_mode,
  input  logic              cmd_ack,
  input  logic              tx_act,
  output logic [NUM_CH-1:0] done,
  output logic [NUM_CH-1:0] err,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RETRY,
    S_WAIT_TX,
    S_GAP
  } state_t;

  localparam logic [CNT_W-1:0] ACK_LAST =
    CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TX_LAST =
    CNT_W'(TX_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST =
    CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] RETRY_MAX =
    CNT_W'(MAX_RETRY);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic [CNT_W-1:0]  retries;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] gnt_mask;
  logic [NUM_CH-1:0] ch_mask;
  logic [NUM_CH-1:0] fin_done;
  logic [NUM_CH-1:0] fin_err;
  logic [CHW-1:0]    rr;
  logic [CHW-1:0]    gnt_idx;
  logic              gnt_vld;
  logic              tx_act_d;
  logic              fall;
  logic              ack_to;
  logic              tx_to;
  logic              gap_end;
  logic              retry_ok;

  // Walk downwards so the nearest pending channel after rr wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      if (pending[(int'(rr) + k) % NUM_CH]) begin
        gnt_vld = 1'b1;
        gnt_idx = CHW'((int'(rr) + k) % NUM_CH);
      end
    end
  end

  assign fall     = tx_act_d & ~tx_act;
  assign retry_ok = retries < RETRY_MAX;
  assign ack_to   = (state == S_REQ) && !cmd_ack
                 && (cnt == ACK_LAST);
  assign tx_to    = (state == S_WAIT_TX) && !fall
                 && (cnt == TX_LAST);
  assign gap_end  = ((state == S_GAP) && (cnt == GAP_LAST))
                 || ((state == S_WAIT_TX) && fall
                     && (GAP_CYCLES == 0));

  assign ch_mask  = NUM_CH'(1) << cmd_ch;
  assign fin_done = gap_end ? ch_mask : '0;
  assign fin_err  = ((ack_to && !retry_ok) || tx_to)
                  ? ch_mask : '0;
  assign gnt_mask = ((state == S_IDLE) && gnt_vld)
                  ? (NUM_CH'(1) << gnt_idx) : '0;
  assign cnt_inc  = (cnt == '1) ? cnt : cnt + CNT_W'(1);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      cmd_rq   <= 1'b0;
      cmd_ch   <= '0;
      hs_mode  <= 1'b0;
      done     <= '0;
      err      <= '0;
      pending  <= '0;
      rr       <= '0;
      cnt      <= '0;
      retries  <= '0;
      tx_act_d <= 1'b0;
    end else begin
      tx_act_d <= tx_act;
      // A start in the same cycle beats a grant or completion.
      pending  <= (pending & ~gnt_mask) | start;
      done     <= (done | fin_done) & ~start;
      err      <= (err | fin_err) & ~start;
      cnt      <= cnt_inc;
      unique case (state)
        S_IDLE: begin
          cnt     <= '0;
          retries <= '0;
          if (gnt_vld) begin
            cmd_ch  <= gnt_idx;
            hs_mode <= hs_cfg[gnt_idx];
            rr      <= gnt_idx;
            cmd_rq  <= 1'b1;
            state   <= S_REQ;
          end
        end
        S_REQ: begin
          if (cmd_ack) begin
            cmd_rq  <= 1'b0;
            cnt     <= '0;
            retries <= '0;
            state   <= S_WAIT_TX;
          end else if (ack_to) begin
            cmd_rq <= 1'b0;
            cnt    <= '0;
            if (retry_ok) begin
              retries <= retries + CNT_W'(1);
              state   <= S_RETRY;
            end else begin
              retries <= '0;
              state   <= S_IDLE;
            end
          end
        end
        S_RETRY: begin
          cnt    <= '0;
          cmd_rq <= 1'b1;
          state  <= S_REQ;
        end
        S_WAIT_TX: begin
          if (fall) begin
            cnt   <= '0;
            state <= (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
          end else if (tx_to) begin
            cnt   <= '0;
            state <= S_IDLE;
          end
        end
        S_GAP: begin
          if (gap_end) begin
            cnt   <= '0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mipi_cmd_seq.sv
// Bench for mipi_cmd_seq: per-cycle reference model compare plus
// directed scenarios with hand-derived timing and ordering checks.
module tb_mipi_cmd_seq;

  localparam int NCH    = 4;
  localparam int ACK_TO = 8;
  localparam int MRETRY = 2;
  localparam int TX_TO  = 50;
  localparam int GAP    = 5;

  localparam int M_IDLE  = 0;
  localparam int M_REQ   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_TX    = 3;
  localparam int M_GAP   = 4;

  logic       clkin = 1'b0;
  logic       rstn = 1'b0;
  logic [3:0] start = '0;
  logic [3:0] hs_cfg = '0;
  logic       cmd_ack = 1'b0;
  logic       tx_act = 1'b0;
  logic       cmd_rq;
  logic [1:0] cmd_ch;
  logic       hs_mode;
  logic [3:0] done;
  logic [3:0] err;
  logic       busy;

  mipi_cmd_seq #(
    .NUM_CH(NCH),
    .CNT_W(16),
    .ACK_TIMEOUT(ACK_TO),
    .MAX_RETRY(MRETRY),
    .TX_TIMEOUT(TX_TO),
    .GAP_CYCLES(GAP)
  ) dut (
    .clkin(clkin),
    .rstn(rstn),
    .start(start),
    .hs_cfg(hs_cfg),
    .cmd_rq(cmd_rq),
    .cmd_ch(cmd_ch),
    .hs_mode(hs_mode),
    .cmd_ack(cmd_ack),
    .tx_act(tx_act),
    .done(done),
    .err(err),
    .busy(busy)
  );

  always #5 clkin = ~clkin;

  int n_chk = 0;
  int n_pass = 0;
  int n_cfail = 0;
  int cyc = 0;

  // responder knobs and records
  int ack_dly = 0;
  int tx_len = 0;
  bit tx_hold = 1'b0;
  int rq_cnt = 0;
  int tx_rem = 0;
  bit ack_pend = 1'b0;
  int ack_cyc = 0;
  int fall_cyc = 0;

  // monitor records
  int gq[$];
  int hq[$];
  int dq[$];
  int bq[$];
  int blen = 0;
  int done_rise[4];
  int err_rise[4];
  logic [3:0] pdone = '0;
  logic [3:0] perr = '0;

  // reference model
  int m_ph = M_IDLE;
  int m_el = 0;
  int m_tries = 0;
  int m_rr = 0;
  int m_ch = 0;
  int fnd = -1;
  bit m_hs = 1'b0;
  bit m_prev = 1'b0;
  bit m_fall = 1'b0;
  logic [3:0] m_pend = '0;
  logic [3:0] m_done = '0;
  logic [3:0] m_err = '0;
  logic [3:0] sd = '0;
  logic [3:0] se = '0;
  logic [3:0] gm = '0;
  logic [12:0] exp_v;
  logic [12:0] act_v;

  task automatic chk(input string nm, input int a, input int e);
    n_chk++;
    if (a == e) n_pass++;
    else $display("FAIL %s: got %0d want %0d", nm, a, e);
  endtask

  task automatic to_fail(input string nm);
    n_chk++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clkin);
  endtask

  task automatic pulse(input logic [3:0] m);
    @(negedge clkin);
    start = m;
    @(negedge clkin);
    start = '0;
  endtask

  task automatic wait_quiet(input string nm, input int lim);
    int q = 0;
    int i = 0;
    while (q < 3 && i < lim) begin
      @(negedge clkin);
      i++;
      if (!busy && !cmd_rq) q++;
      else q = 0;
    end
    if (q < 3) to_fail(nm);
  endtask

  task automatic model_step();
    m_fall = m_prev && !tx_act;
    sd = '0;
    se = '0;
    gm = '0;
    case (m_ph)
      M_IDLE: if (m_pend != 0) begin
        fnd = -1;
        for (int k = 1; k <= NCH; k++)
          if (fnd < 0 && m_pend[(m_rr + k) % NCH])
            fnd = (m_rr + k) % NCH;
        gm[fnd] = 1'b1;
        m_ch = fnd;
        m_hs = hs_cfg[fnd];
        m_rr = fnd;
        m_ph = M_REQ;
        m_el = 0;
        m_tries = 0;
      end
      M_REQ: begin
        m_el++;
        if (cmd_ack) begin
          m_ph = M_TX;
          m_el = 0;
        end else if (m_el == ACK_TO) begin
          if (m_tries < MRETRY) begin
            m_tries++;
            m_ph = M_PAUSE;
          end else begin
            se[m_ch] = 1'b1;
            m_ph = M_IDLE;
          end
        end
      end
      M_PAUSE: begin
        m_ph = M_REQ;
        m_el = 0;
      end
      M_TX: begin
        m_el++;
        if (m_fall) begin
          if (GAP == 0) begin
            sd[m_ch] = 1'b1;
            m_ph = M_IDLE;
          end else begin
            m_ph = M_GAP;
            m_el = 0;
          end
        end else if (m_el == TX_TO) begin
          se[m_ch] = 1'b1;
          m_ph = M_IDLE;
        end
      end
      M_GAP: begin
        m_el++;
        if (m_el == GAP) begin
          sd[m_ch] = 1'b1;
          m_ph = M_IDLE;
        end
      end
      default: m_ph = M_IDLE;
    endcase
    m_pend = (m_pend & ~gm) | start;
    m_done = (m_done | sd) & ~start;
    m_err = (m_err | se) & ~start;
    m_prev = tx_act;
  endtask

  task automatic model_clear();
    m_ph = M_IDLE;
    m_el = 0;
    m_tries = 0;
    m_rr = 0;
    m_ch = 0;
    m_hs = 1'b0;
    m_prev = 1'b0;
    m_pend = '0;
    m_done = '0;
    m_err = '0;
  endtask

  task automatic negedge_work();
    exp_v = {m_ph == M_REQ, 2'(m_ch), m_hs,
             m_done, m_err, m_ph != M_IDLE};
    act_v = {cmd_rq, cmd_ch, hs_mode, done, err, busy};
    n_chk++;
    if (act_v === exp_v) n_pass++;
    else begin
      n_cfail++;
      if (n_cfail <= 10)
        $display("FAIL cyc%0d outputs: got %b want %b",
                 cyc, act_v, exp_v);
    end
    if (cmd_rq) begin
      if (blen == 0) begin
        gq.push_back(int'(cmd_ch));
        hq.push_back(int'(hs_mode));
        dq.push_back(int'(done));
      end
      blen++;
    end else if (blen > 0) begin
      bq.push_back(blen);
      blen = 0;
    end
    for (int i = 0; i < 4; i++) begin
      if (done[i] && !pdone[i]) done_rise[i] = cyc;
      if (err[i] && !perr[i]) err_rise[i] = cyc;
    end
    pdone = done;
    perr = err;
    if (!rstn) begin
      cmd_ack = 1'b0;
      tx_act = 1'b0;
      rq_cnt = 0;
      tx_rem = 0;
      ack_pend = 1'b0;
    end else begin
      if (ack_pend) begin
        cmd_ack = 1'b0;
        ack_pend = 1'b0;
        tx_act = 1'b1;
        tx_rem = tx_len;
      end else if (tx_act) begin
        if (tx_rem > 1) tx_rem--;
        else if (!tx_hold) begin
          tx_act = 1'b0;
          fall_cyc = cyc;
        end
      end
      if (cmd_rq) begin
        rq_cnt++;
        if (ack_dly != 0 && rq_cnt == ack_dly) begin
          cmd_ack = 1'b1;
          ack_pend = 1'b1;
          ack_cyc = cyc;
        end
      end else rq_cnt = 0;
    end
  endtask

  initial begin
    int b;
    int bb;
    int f0;
    int i;
    fork
      forever begin
        @(posedge clkin or negedge rstn);
        if (!rstn) model_clear();
        else begin
          cyc++;
          model_step();
        end
      end
      forever begin
        @(negedge clkin);
        negedge_work();
      end
    join_none

    tick(3);
    chk("rst_rq", int'(cmd_rq), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_ch", int'(cmd_ch), 0);
    chk("rst_hs", int'(hs_mode), 0);
    rstn = 1'b1;
    tick(2);

    // three channels at once from rr=0
    hs_cfg = 4'b0010;
    ack_dly = 2;
    tx_len = 3;
    b = gq.size();
    pulse(4'b1011);
    wait_quiet("t2_wait", 300);
    chk("t2_cnt", gq.size() - b, 3);
    chk("t2_g0", qget(gq, b), 1);
    chk("t2_g1", qget(gq, b + 1), 3);
    chk("t2_g2", qget(gq, b + 2), 0);
    chk("t2_hs0", qget(hq, b), 1);
    chk("t2_hs1", qget(hq, b + 1), 0);
    chk("t2_hs2", qget(hq, b + 2), 0);
    chk("t2_done1", (qget(dq, b + 1) >> 1) & 1, 1);
    chk("t2_done3", (qget(dq, b + 2) >> 3) & 1, 1);
    chk("t2_done", int'(done), 4'b1011);

    // single packet, ack on 3rd request cycle
    hs_cfg = 4'b0100;
    ack_dly = 3;
    tx_len = 10;
    b = gq.size();
    bb = bq.size();
    pulse(4'b0100);
    wait_quiet("t1_wait", 300);
    chk("t1_ch", qget(gq, b), 2);
    chk("t1_hs", qget(hq, b), 1);
    chk("t1_rqlen", qget(bq, bb), 3);
    chk("t1_gap", done_rise[2] - fall_cyc, GAP + 1);
    chk("t1_done", int'(done), 4'b1111);

    // no ack: three bursts then err
    ack_dly = 0;
    bb = bq.size();
    pulse(4'b0010);
    wait_quiet("t3_wait", 300);
    chk("t3_bursts", bq.size() - bb, 3);
    chk("t3_len0", qget(bq, bb), ACK_TO);
    chk("t3_len1", qget(bq, bb + 1), ACK_TO);
    chk("t3_len2", qget(bq, bb + 2), ACK_TO);
    chk("t3_err", int'(err), 4'b0010);
    chk("t3_done", int'(done), 4'b1101);
    chk("t3_busy", int'(busy), 0);

    // tx_act never falls
    ack_dly = 2;
    tx_len = 5;
    tx_hold = 1'b1;
    pulse(4'b1000);
    wait_quiet("t4_wait", 300);
    chk("t4_tlat", err_rise[3] - ack_cyc, TX_TO + 1);
    chk("t4_err", int'(err), 4'b1010);
    chk("t4_done", int'(done), 4'b0101);
    tx_hold = 1'b0;
    tick(3);
    tx_len = 4;
    pulse(4'b1000);
    chk("t4_clr", int'(err[3]), 0);
    wait_quiet("t4_wait2", 300);
    chk("t4_redo", int'(done[3]), 1);
    chk("t4_err2", int'(err), 4'b0010);

    // reset in the gap
    ack_dly = 1;
    tx_len = 3;
    f0 = fall_cyc;
    pulse(4'b0001);
    i = 0;
    while (fall_cyc == f0 && i < 100) begin
      @(negedge clkin);
      i++;
    end
    if (fall_cyc == f0) to_fail("t5_fall");
    tick(2);
    chk("t5_gap_busy", int'(busy), 1);
    @(posedge clkin);
    #3 rstn = 1'b0;
    #1;
    chk("t5_rq", int'(cmd_rq), 0);
    chk("t5_busy", int'(busy), 0);
    chk("t5_done", int'(done), 0);
    chk("t5_err", int'(err), 0);
    chk("t5_ch", int'(cmd_ch), 0);
    tick(3);
    rstn = 1'b1;
    b = gq.size();
    tick(10);
    chk("t5_idle_rq", gq.size() - b, 0);
    chk("t5_idle_done", int'(done), 0);
    ack_dly = 2;
    tx_len = 4;
    pulse(4'b0100);
    wait_quiet("t5_wait", 300);
    chk("t5_g", qget(gq, b), 2);
    chk("t5_fresh", int'(done), 4'b0100);

    // re-start of the channel in flight
    ack_dly = 2;
    tx_len = 8;
    b = gq.size();
    pulse(4'b0010);
    i = 0;
    while (!tx_act && i < 50) begin
      @(negedge clkin);
      i++;
    end
    if (!tx_act) to_fail("t6_tx");
    pulse(4'b0011);
    wait_quiet("t6_wait", 500);
    chk("t6_cnt", gq.size() - b, 3);
    chk("t6_g0", qget(gq, b), 1);
    chk("t6_g1", qget(gq, b + 1), 0);
    chk("t6_g2", qget(gq, b + 2), 1);
    chk("t6_done", int'(done), 4'b0111);
    chk("t6_err", int'(err), 0);

    // reset while requesting
    ack_dly = 0;
    pulse(4'b1000);
    i = 0;
    while (!cmd_rq && i < 20) begin
      @(negedge clkin);
      i++;
    end
    if (!cmd_rq) to_fail("t7_rq");
    @(posedge clkin);
    #3 rstn = 1'b0;
    #1;
    chk("t7_rq", int'(cmd_rq), 0);
    chk("t7_busy", int'(busy), 0);
    tick(2);
    rstn = 1'b1;
    tick(5);
    chk("t7_idle", int'(cmd_rq), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
